uart_receiver: RTL



---
 rtl/uart_receiver_pkg.sv | 14 +
 rtl/uart_receiver_sync_2ff.sv | 17 +
 rtl/uart_receiver.sv | 104 ++++++++++
 3 files changed

// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg: shared state encoding, default baud divisor and vote helper
package uart_receiver_pkg;
  localparam int CLKS_PER_BIT_DEFAULT = 61;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } state_t;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// uart_receiver_sync_2ff: two-flop synchroniser with a parameterised reset value
module uart_receiver_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  // capture the asynchronous pin and let the first stage settle for one cycle
  always_ff @(posedge clk_in) begin
    s1_q <= reset ? RST_VAL : d;
    s2_q <= reset ? RST_VAL : s1_q;
  end
  assign q = s2_q;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver with 3-point majority vote per bit, valid and framing-error strobes
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       rx_running
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] S0 = CW'(HALF - 1);
  localparam logic [CW-1:0] S1 = CW'(HALF);
  localparam logic [CW-1:0] S2 = CW'(HALF + 1);
  logic rx_s, vote, at_vote, at_last;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic [1:0] smp_q, smp_d;
  logic data_valid_q, data_valid_d, framing_error_q, framing_error_d, rx_running_q;
  uart_receiver_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_in(clk_in),
    .reset (reset),
    .d     (uart_rx),
    .q     (rx_s)
  );
  assign at_vote = cnt_q == S2;
  assign at_last = cnt_q == LAST;
  assign vote = maj3(smp_q[1], smp_q[0], rx_s);
  // next state: the third sample joins the two held ones, so decisions land on cnt=HALF+1
  always_comb begin
    state_d = state_q;
    cnt_d = at_last ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    shift_d = shift_q;
    data_d = data_q;
    data_valid_d = 1'b0;
    framing_error_d = 1'b0;
    smp_d = {cnt_q == S0 ? rx_s : smp_q[1], cnt_q == S1 ? rx_s : smp_q[0]};
    case (state_q)
      IDLE: state_d = rx_s ? IDLE : START;
      START: begin
        if (at_vote && vote) state_d = IDLE;
        else if (at_last) begin
          state_d = DATA;
          idx_d = '0;
        end
      end
      DATA: begin
        shift_d = at_vote ? {vote, shift_q[7:1]} : shift_q;
        if (at_last) begin
          idx_d = idx_q + 3'd1;
          state_d = idx_q == 3'd7 ? STOP : DATA;
        end
      end
      STOP: begin
        if (at_vote) begin
          state_d = vote ? IDLE : BREAK_WAIT;
          data_valid_d = vote;
          framing_error_d = !vote;
          data_d = vote ? shift_q : data_q;
        end
      end
      BREAK_WAIT: state_d = rx_s ? IDLE : BREAK_WAIT;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? '0 : cnt_d;
  end
  // state and output registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      smp_q <= '0;
      data_q <= '0;
      data_valid_q <= 1'b0;
      framing_error_q <= 1'b0;
      rx_running_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      smp_q <= smp_d;
      data_q <= data_d;
      data_valid_q <= data_valid_d;
      framing_error_q <= framing_error_d;
      rx_running_q <= state_d != IDLE;
    end
  end
  assign data = data_q;
  assign data_valid = data_valid_q;
  assign framing_error = framing_error_q;
  assign rx_running = rx_running_q;
endmodule
